buffer_scheduler: RTL and testbench
===================================

BUFFER_SCHEDULER -- requirements
Module: buffer_scheduler

Interface
REQ-001 Parameter NO_BUFS, default 8: number of pattern buffers; index width 3 bits.
REQ-002 Parameter SEQ_LEN, default 8: sequence table entries.
REQ-003 Parameter HOLD_W, default 8: width of the per-entry hold count.
REQ-004 Ports are listed below as name  direction  width  meaning.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 cfg_we  in  1  write the sequence-table entry at cfg_addr.
REQ-008 cfg_addr  in  3  table entry index.
REQ-009 cfg_buf  in  3  buffer index stored in the entry.
REQ-010 cfg_hold  in  HOLD_W  hold count stored in the entry.
REQ-011 seq_len  in  4  active entries; 0 is treated as 1, values above SEQ_LEN as SEQ_LEN.
REQ-012 start  in  1  single-cycle start request.
REQ-013 stop  in  1  single-cycle stop request.
REQ-014 tick  in  1  display advance strobe.
REQ-015 buffer_select  out  3  buffer currently displayed; registered.
REQ-016 seq_idx  out  3  current table entry; registered.
REQ-017 running  out  1  high in states RUN and STOPPING.
REQ-018 wrap  out  1  one-cycle pulse when seq_idx wraps to 0.
REQ-019 edit_req  in  1  requester wants field access.
REQ-020 edit_buf  in  3  buffer the requester targets.
REQ-021 edit_wr  in  1  request is a write.
REQ-022 edit_ack  out  1  one-cycle pulse, request accepted.
REQ-023 bufp  out  3  registered buffer pointer to the pattern buffers.
REQ-024 field_write  out  1  registered write strobe to the pattern buffers.

Function
REQ-025 The FSM SHALL have the states IDLE, RUN and STOPPING.
REQ-026 In IDLE, start SHALL enter RUN with seq_idx=0, buffer_select=tbl[0].buf and cnt=tbl[0].hold, all effective the next cycle.
REQ-027 In RUN or STOPPING, a tick with cnt>0 SHALL decrement cnt, so each entry is displayed for hold+1 ticks.
REQ-028 In RUN, a tick with cnt==0 SHALL advance seq_idx, reload cnt and update buffer_select from the new entry.
REQ-029 An advance from seq_idx == effective seq_len-1 SHALL set seq_idx to 0 and pulse wrap in the same cycle as the update.
REQ-030 stop in RUN SHALL enter STOPPING.
REQ-031 In STOPPING, a tick with cnt==0 SHALL enter IDLE with buffer_select and seq_idx frozen.
REQ-032 start in STOPPING SHALL return to RUN without disturbing cnt or seq_idx.
REQ-033 When start and stop are asserted together, stop SHALL win; in IDLE they SHALL have no effect.
REQ-034 start in RUN and stop in IDLE SHALL be ignored.
REQ-035 Table writes SHALL be accepted in any state and take effect when the entry is next loaded.
REQ-036 A write to an entry at the same edge it is loaded SHALL load the old value.
REQ-037 A request SHALL be blocked when running is high and edit_buf equals either the current buffer_select or the value buffer_select takes at the same edge.
REQ-038 A blocked request SHALL produce no edit_ack and field_write=0; the requester holds it until accepted.
REQ-039 When not running, every request SHALL be accepted.
REQ-040 An accepted request SHALL register bufp<=edit_buf, field_write<=edit_wr and edit_ack=1 in the following cycle; latency is 1.
REQ-041 Back-to-back accepted requests SHALL be accepted on consecutive cycles.
REQ-042 bufp SHALL hold its value while no request is accepted.

Reset
REQ-043 rst SHALL set the state to IDLE.
REQ-044 rst SHALL clear buffer_select, seq_idx, cnt, wrap, edit_ack, bufp and field_write to 0.
REQ-045 rst SHALL clear every table entry to buf=0, hold=0.
REQ-046 rst asserted mid-sequence or mid-edit SHALL take priority over all other inputs in that cycle.

Structure
REQ-047 A shared package pat_sched_pkg SHALL hold NO_BUFS, SEQ_LEN, HOLD_W, the state enum and the entry struct {buf, hold}.
REQ-048 The table register file SHALL be a sub-module seq_table with one write port and one combinational read port.
REQ-049 The FSM, counter and edit guard SHALL reside in buffer_scheduler.

Verification
REQ-050 Program tbl={(2,1),(5,0)} with seq_len=2, start, then tick every cycle -> buffer_select 2,2,5,2,2,5; wrap pulses with each return to 2.
REQ-051 Set seq_len=0 and tbl[0]=(3,2), then start -> buffer_select stays 3; wrap pulses every 3 ticks.
REQ-052 Issue stop while on entry 0 with hold=4 after 1 tick -> 4 more ticks, then IDLE; running=0; buffer_select unchanged.
REQ-053 While buffer 5 is displayed, request edit_req for buffer 5 and for buffer 1 -> the request for 5 stalls until the display leaves 5; the request for 1 acks after 1 cycle with bufp=1 and field_write=edit_wr.
REQ-054 On the cycle a tick advances the display to buffer 4, request edit_buf=4 -> no ack and field_write=0.
REQ-055 Assert rst during RUN with cnt=3 -> next cycle all outputs 0, state IDLE, and a subsequent start uses a cleared table (buffer_select=0).

Source files
------------

// File: rtl/pat_sched_pkg.sv
// Shared types and sizing for the pattern-buffer display scheduler.
package pat_sched_pkg;
    localparam int NO_BUFS = 8;
    localparam int SEQ_LEN = 8;
    localparam int HOLD_W  = 8;
    localparam int BUF_W   = $clog2(NO_BUFS);
    localparam int IDX_W   = 3;
    localparam int LEN_W   = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_e;

    typedef struct packed {
        logic [BUF_W-1:0]  buf_idx;
        logic [HOLD_W-1:0] hold;
    } entry_t;
endpackage

// File: rtl/seq_table.sv
// Sequence table register file: one synchronous write port, one combinational read port.
// Reads see the pre-write contents, so a load coinciding with a write gets the old entry.
module seq_table
    import pat_sched_pkg::*;
#(
    parameter int DEPTH = pat_sched_pkg::SEQ_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  entry_t           i_wdat,
    input  logic [IDX_W-1:0] i_raddr,
    output entry_t           o_rdat
);
    entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdat;
        end
    end

    assign o_rdat = r_mem[i_raddr];
endmodule

// File: rtl/buffer_scheduler.sv
// Steps through a table of (buffer, hold) entries on tick strobes and guards
// editor access so the displayed buffer is never written while it is on screen.
module buffer_scheduler
    import pat_sched_pkg::*;
#(
    parameter int NO_BUFS = pat_sched_pkg::NO_BUFS,
    parameter int SEQ_LEN = pat_sched_pkg::SEQ_LEN,
    parameter int HOLD_W  = pat_sched_pkg::HOLD_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cfg_we,
    input  logic [2:0]                      cfg_addr,
    input  logic [$clog2(NO_BUFS)-1:0]      cfg_buf,
    input  logic [HOLD_W-1:0]               cfg_hold,
    input  logic [3:0]                      seq_len,
    input  logic                            start,
    input  logic                            stop,
    input  logic                            tick,
    output logic [$clog2(NO_BUFS)-1:0]      buffer_select,
    output logic [2:0]                      seq_idx,
    output logic                            running,
    output logic                            wrap,
    input  logic                            edit_req,
    input  logic [$clog2(NO_BUFS)-1:0]      edit_buf,
    input  logic                            edit_wr,
    output logic                            edit_ack,
    output logic [$clog2(NO_BUFS)-1:0]      bufp,
    output logic                            field_write
);
    localparam int BW = $clog2(NO_BUFS);

    state_e            r_state, w_state_nxt;
    logic [2:0]        r_seq_idx, w_idx_nxt, w_rd_addr;
    logic [BW-1:0]     r_buf_sel, w_buf_nxt;
    logic [HOLD_W-1:0] r_cnt, w_cnt_nxt;
    logic              r_wrap, w_wrap_nxt;
    logic              r_edit_ack, r_field_write;
    logic [BW-1:0]     r_bufp;
    logic [3:0]        w_eff_len;
    logic              w_last, w_go, w_running, w_blocked, w_accept;
    entry_t            w_entry, w_cfg_entry;

    assign w_cfg_entry = '{buf_idx: cfg_buf, hold: cfg_hold};

    seq_table #(.DEPTH(SEQ_LEN)) u_seq_table (
        .clk     (clk),
        .rst     (rst),
        .i_we    (cfg_we),
        .i_waddr (cfg_addr),
        .i_wdat  (w_cfg_entry),
        .i_raddr (w_rd_addr),
        .o_rdat  (w_entry)
    );

    always_comb begin
        w_eff_len = seq_len;
        if (seq_len == 4'd0) begin
            w_eff_len = 4'd1;
        end else if (seq_len > 4'(SEQ_LEN)) begin
            w_eff_len = 4'(SEQ_LEN);
        end
    end

    // >= so a sequence shortened mid-run still wraps instead of overrunning
    assign w_last    = ({1'b0, r_seq_idx} >= (w_eff_len - 4'd1));
    assign w_rd_addr = ((r_state == IDLE) || w_last) ? 3'd0 : r_seq_idx + 3'd1;
    assign w_go      = start && !stop;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_seq_idx;
        w_buf_nxt   = r_buf_sel;
        w_cnt_nxt   = r_cnt;
        w_wrap_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_go) begin
                    w_state_nxt = RUN;
                    w_idx_nxt   = 3'd0;
                    w_buf_nxt   = w_entry.buf_idx;
                    w_cnt_nxt   = w_entry.hold;
                end
            end
            RUN: begin
                if (tick) begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end else begin
                        w_idx_nxt  = w_rd_addr;
                        w_buf_nxt  = w_entry.buf_idx;
                        w_cnt_nxt  = w_entry.hold;
                        w_wrap_nxt = w_last;
                    end
                end
                if (stop) begin
                    w_state_nxt = STOPPING;
                end
            end
            STOPPING: begin
                // A resume takes precedence over a tick in the same cycle
                if (w_go) begin
                    w_state_nxt = RUN;
                end else if (tick) begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_running = (r_state != IDLE);
    assign w_blocked = w_running && ((edit_buf == r_buf_sel) || (edit_buf == w_buf_nxt));
    assign w_accept  = edit_req && !w_blocked;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_seq_idx     <= '0;
            r_buf_sel     <= '0;
            r_cnt         <= '0;
            r_wrap        <= 1'b0;
            r_edit_ack    <= 1'b0;
            r_field_write <= 1'b0;
            r_bufp        <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_seq_idx     <= w_idx_nxt;
            r_buf_sel     <= w_buf_nxt;
            r_cnt         <= w_cnt_nxt;
            r_wrap        <= w_wrap_nxt;
            r_edit_ack    <= w_accept;
            r_field_write <= w_accept && edit_wr;
            if (w_accept) begin
                r_bufp <= edit_buf;
            end
        end
    end

    assign buffer_select = r_buf_sel;
    assign seq_idx       = r_seq_idx;
    assign running       = w_running;
    assign wrap          = r_wrap;
    assign edit_ack      = r_edit_ack;
    assign bufp          = r_bufp;
    assign field_write   = r_field_write;
endmodule

// File: tb/tb_buffer_scheduler.sv
// Directed scenarios plus randomized traffic, checked every cycle against a behavioural model.
module tb_buffer_scheduler;
    logic       clk = 1'b0;
    logic       rst, cfg_we, start, stop, tick, edit_req, edit_wr;
    logic [2:0] cfg_addr, cfg_buf, edit_buf;
    logic [7:0] cfg_hold;
    logic [3:0] seq_len;
    logic [2:0] buffer_select, seq_idx, bufp;
    logic       running, wrap, edit_ack, field_write;

    int n_vec = 0;
    int n_err = 0;

    // behavioural reference state
    int m_mode;   // 0 idle, 1 run, 2 stopping
    int m_idx, m_cnt, m_buf, m_bufp;
    bit m_wrap, m_ack, m_fw;
    int t_buf [8];
    int t_hold[8];

    always #5 clk = ~clk;

    buffer_scheduler dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_buf(cfg_buf),
        .cfg_hold(cfg_hold), .seq_len(seq_len), .start(start), .stop(stop), .tick(tick),
        .buffer_select(buffer_select), .seq_idx(seq_idx), .running(running), .wrap(wrap),
        .edit_req(edit_req), .edit_buf(edit_buf), .edit_wr(edit_wr), .edit_ack(edit_ack),
        .bufp(bufp), .field_write(field_write)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int len, n_mode, n_idx, n_cnt, n_buf;
        bit n_wrap, go, blocked, acc;
        if (rst) begin
            m_mode = 0; m_idx = 0; m_cnt = 0; m_buf = 0; m_bufp = 0;
            m_wrap = 0; m_ack = 0; m_fw = 0;
            for (int i = 0; i < 8; i++) begin t_buf[i] = 0; t_hold[i] = 0; end
            return;
        end
        len = (seq_len == 0) ? 1 : ((seq_len > 8) ? 8 : int'(seq_len));
        n_mode = m_mode; n_idx = m_idx; n_cnt = m_cnt; n_buf = m_buf; n_wrap = 0;
        go = start && !stop;
        if (m_mode == 0) begin
            if (go) begin
                n_mode = 1; n_idx = 0; n_buf = t_buf[0]; n_cnt = t_hold[0];
            end
        end else if (m_mode == 1) begin
            if (tick) begin
                if (m_cnt > 0) n_cnt = m_cnt - 1;
                else begin
                    n_wrap = (m_idx >= len - 1);
                    n_idx  = n_wrap ? 0 : m_idx + 1;
                    n_buf  = t_buf[n_idx];
                    n_cnt  = t_hold[n_idx];
                end
            end
            if (stop) n_mode = 2;
        end else begin
            if (go) n_mode = 1;
            else if (tick) begin
                if (m_cnt > 0) n_cnt = m_cnt - 1;
                else n_mode = 0;
            end
        end
        blocked = (m_mode != 0) && ((int'(edit_buf) == m_buf) || (int'(edit_buf) == n_buf));
        acc = edit_req && !blocked;
        m_ack = acc;
        m_fw  = acc && edit_wr;
        if (acc) m_bufp = edit_buf;
        if (cfg_we) begin
            t_buf[cfg_addr]  = cfg_buf;
            t_hold[cfg_addr] = cfg_hold;
        end
        m_mode = n_mode; m_idx = n_idx; m_cnt = n_cnt; m_buf = n_buf; m_wrap = n_wrap;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("buffer_select", buffer_select, m_buf);
        chk("seq_idx", seq_idx, m_idx);
        chk("running", running, m_mode != 0);
        chk("wrap", wrap, m_wrap);
        chk("edit_ack", edit_ack, m_ack);
        chk("bufp", bufp, m_bufp);
        chk("field_write", field_write, m_fw);
    endtask

    task automatic quiet();
        rst = 0; cfg_we = 0; start = 0; stop = 0; tick = 0; edit_req = 0; edit_wr = 0;
        cfg_addr = 0; cfg_buf = 0; cfg_hold = 0; edit_buf = 0;
    endtask

    task automatic do_reset();
        quiet(); rst = 1; cycle(); rst = 0;
    endtask

    task automatic cfg(input int a, input int b, input int h);
        cfg_we = 1; cfg_addr = 3'(a); cfg_buf = 3'(b); cfg_hold = 8'(h);
        cycle();
        cfg_we = 0;
    endtask

    task automatic do_start();
        start = 1; cycle(); start = 0;
    endtask

    initial begin
        int exp_bs[6];
        int exp_wr[6];
        int wraps, waited;
        exp_bs = '{2, 5, 2, 2, 5, 2};
        exp_wr = '{0, 0, 1, 0, 0, 1};
        quiet(); seq_len = 2;
        do_reset();
        chk("reset_running", running, 0);
        chk("reset_bufsel", buffer_select, 0);

        // two-entry sequence, tick every cycle
        cfg(0, 2, 1); cfg(1, 5, 0);
        do_start();
        chk("start_bufsel", buffer_select, 2);
        tick = 1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("seq2_bufsel", buffer_select, exp_bs[i]);
            chk("seq2_wrap", wrap, exp_wr[i]);
        end
        tick = 0;

        // seq_len 0 behaves as one entry
        do_reset();
        seq_len = 0; cfg(0, 3, 2);
        do_start();
        tick = 1; wraps = 0;
        for (int i = 0; i < 9; i++) begin
            cycle();
            chk("len0_bufsel", buffer_select, 3);
            if (wrap) wraps++;
            chk("len0_wrap", wrap, ((i % 3) == 2));
        end
        chk("len0_wrap_count", wraps, 3);
        tick = 0;

        // stop after one tick with hold 4 drains remaining ticks
        do_reset();
        seq_len = 1; cfg(0, 6, 4);
        do_start();
        tick = 1; cycle(); tick = 0;
        stop = 1; cycle(); stop = 0;
        chk("stopping_running", running, 1);
        tick = 1;
        for (int i = 0; i < 3; i++) cycle();
        chk("stop_still_running", running, 1);
        cycle();
        chk("stop_idle", running, 0);
        chk("stop_bufsel_frozen", buffer_select, 6);
        tick = 0;

        // edit guard against the displayed buffer
        do_reset();
        seq_len = 2; cfg(0, 5, 2); cfg(1, 6, 0);
        do_start();
        edit_req = 1; edit_buf = 1; edit_wr = 1; cycle();
        chk("edit1_ack", edit_ack, 1);
        chk("edit1_bufp", bufp, 1);
        chk("edit1_fw", field_write, 1);
        edit_buf = 5; edit_wr = 1; tick = 1; waited = 0;
        while (buffer_select == 5 && waited < 20) begin
            cycle();
            chk("edit5_stall_ack", edit_ack, 0);
            waited++;
        end
        chk("edit5_left_display", buffer_select != 5, 1);
        tick = 0; cycle();
        chk("edit5_ack", edit_ack, 1);
        chk("edit5_bufp", bufp, 5);
        edit_req = 0; cycle();

        // request for the buffer being switched in on the same edge
        do_reset();
        seq_len = 2; cfg(0, 2, 0); cfg(1, 4, 0);
        do_start();
        tick = 1; edit_req = 1; edit_buf = 4; edit_wr = 1; cycle();
        chk("sw4_bufsel", buffer_select, 4);
        chk("sw4_ack", edit_ack, 0);
        chk("sw4_fw", field_write, 0);
        quiet();

        // reset mid-run with all inputs active
        do_reset();
        seq_len = 1; cfg(0, 6, 3);
        do_start();
        rst = 1; start = 1; tick = 1; edit_req = 1; edit_buf = 2; cfg_we = 1; cycle();
        chk("rst_running", running, 0);
        chk("rst_bufsel", buffer_select, 0);
        chk("rst_ack", edit_ack, 0);
        quiet();
        do_start();
        chk("rst_cleared_tbl", buffer_select, 0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            cfg_we   = ($urandom_range(0, 7) == 0);
            cfg_addr = 3'($urandom);
            cfg_buf  = 3'($urandom);
            cfg_hold = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) seq_len = 4'($urandom);
            start    = ($urandom_range(0, 9) == 0);
            stop     = ($urandom_range(0, 15) == 0);
            tick     = $urandom_range(0, 1);
            edit_req = ($urandom_range(0, 2) == 0);
            edit_buf = 3'($urandom);
            edit_wr  = $urandom_range(0, 1);
            cycle();
        end
        quiet();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
